// File: rtl/udm_uart_tx.sv
// UART transmitter: byte FIFO feeding an 8N1 / 8-parity-1 serialiser on tx_o, LSB first.
// Latency: byte written into an empty FIFO while idle is popped one edge later, when tx_o falls.
// Backpressure: wr_ack_o = wr_req_i & ~full_o; a write while full is dropped, even if a pop happens that cycle.
module udm_uart_tx #(
  parameter int FIFO_DEPTH = 8,
  parameter int DIV_WIDTH  = 32
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [DIV_WIDTH-1:0]          divider_i,
  input  logic                          parity_en_i,
  input  logic                          parity_odd_i,
  input  logic                          wr_req_i,
  input  logic [7:0]                    wr_data_i,
  output logic                          wr_ack_o,
  output logic                          full_o,
  output logic [$clog2(FIFO_DEPTH):0]   count_o,
  output logic                          busy_o,
  output logic                          tx_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  // FIFO storage and bookkeeping
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count_q;
  logic          fifo_empty;
  logic          wr_en;
  logic          pop;

  // Serialiser state
  state_t               state_q;
  state_t               state_d;
  logic                 tx_q;
  logic                 tx_d;
  logic [DIV_WIDTH-1:0] div_cnt_q;
  logic [DIV_WIDTH-1:0] cfg_div_q;
  logic                 cfg_pen_q;
  logic                 par_bit_q;
  logic [2:0]           bit_idx_q;
  logic [7:0]           shift_q;
  logic                 bit_end;

  assign fifo_empty = (count_q == '0);
  assign full_o     = (count_q == DEPTH_C);
  assign wr_en      = wr_req_i & ~full_o;
  assign wr_ack_o   = wr_en;
  assign count_o    = count_q;
  assign busy_o     = (state_q != S_IDLE);
  assign tx_o       = tx_q;

  // The latched divider is never zero, so the last cycle of a bit is div-1.
  assign bit_end = (div_cnt_q == cfg_div_q - DIV_WIDTH'(1));

  // FIFO pointers and occupancy; pointers wrap naturally since depth is a power of two
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (pop)   rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // FIFO storage write; contents need no reset because occupancy gates every read
  always_ff @(posedge clk_i) begin
    if (wr_en) mem[wr_ptr] <= wr_data_i;
  end

  // FSM state and registered serial line
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      tx_q    <= tx_d;
    end
  end

  // Next state, pop request and next line level
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    tx_d    = tx_q;
    case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = S_START;
          tx_d    = 1'b0;
        end
      end
      S_START: begin
        if (bit_end) begin
          state_d = S_DATA;
          tx_d    = shift_q[0];
        end
      end
      S_DATA: begin
        if (bit_end) begin
          if (bit_idx_q == 3'd7) begin
            if (cfg_pen_q) begin
              state_d = S_PARITY;
              tx_d    = par_bit_q;
            end else begin
              state_d = S_STOP;
              tx_d    = 1'b1;
            end
          end else begin
            // shift_q moves right at this edge, so bit 1 becomes the next line value
            tx_d = shift_q[1];
          end
        end
      end
      S_PARITY: begin
        if (bit_end) begin
          state_d = S_STOP;
          tx_d    = 1'b1;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          if (!fifo_empty) begin
            // chain straight into the next start bit, no idle gap
            pop     = 1'b1;
            state_d = S_START;
            tx_d    = 1'b0;
          end else begin
            state_d = S_IDLE;
            tx_d    = 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  // Frame datapath: load byte and config on pop, then count cycles per bit and shift data
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      div_cnt_q <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      cfg_div_q <= DIV_WIDTH'(1);
      cfg_pen_q <= 1'b0;
      par_bit_q <= 1'b0;
    end else if (pop) begin
      shift_q   <= mem[rd_ptr];
      cfg_div_q <= (divider_i == '0) ? DIV_WIDTH'(1) : divider_i;
      cfg_pen_q <= parity_en_i;
      par_bit_q <= (^mem[rd_ptr]) ^ parity_odd_i;
      div_cnt_q <= '0;
      bit_idx_q <= '0;
    end else if (state_q != S_IDLE) begin
      if (bit_end) begin
        div_cnt_q <= '0;
        if (state_q == S_DATA) begin
          shift_q   <= shift_q >> 1;
          bit_idx_q <= bit_idx_q + 3'd1;
        end
      end else begin
        div_cnt_q <= div_cnt_q + DIV_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_udm_uart_tx.sv
// Testbench for udm_uart_tx: directed frame table, corner sequences, randomised traffic.
// A line decoder rebuilds each frame from tx_o and checks it against a byte scoreboard.
// Inputs are driven on the falling edge; outputs are sampled 1 time unit after it.
module tb_udm_uart_tx;

  logic        clk;
  logic        rst;
  logic [31:0] divider;
  logic        parity_en;
  logic        parity_odd;
  logic        wr_req;
  logic [7:0]  wr_data;
  logic        wr_ack;
  logic        full;
  logic [3:0]  count;
  logic        busy;
  logic        tx;

  udm_uart_tx #(.FIFO_DEPTH(8), .DIV_WIDTH(32)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .divider_i    (divider),
    .parity_en_i  (parity_en),
    .parity_odd_i (parity_odd),
    .wr_req_i     (wr_req),
    .wr_data_i    (wr_data),
    .wr_ack_o     (wr_ack),
    .full_o       (full),
    .count_o      (count),
    .busy_o       (busy),
    .tx_o         (tx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic [7:0] exp_q[$];
  int         start_q[$];
  int         frames_seen = 0;

  // values of the inputs as seen by the DUT at the most recent rising edge
  int cfg_div_e  = 1;
  bit cfg_pen_e  = 0;
  bit cfg_odd_e  = 0;
  bit rst_e      = 1;

  task automatic chk(input string name, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Reference frame: start 0, data LSB first, optional parity, stop 1; unused slots read 1
  function automatic logic [0:10] ref_line(input logic [7:0] b, input bit pen, input bit odd);
    logic [0:10] l;
    l = '1;
    l[0] = 1'b0;
    for (int i = 0; i < 8; i++) l[1+i] = b[i];
    if (pen) l[9] = (^b) ^ odd;
    return l;
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      cfg_div_e = (divider == 0) ? 1 : int'(divider);
      cfg_pen_e = parity_en;
      cfg_odd_e = parity_odd;
      rst_e     = rst;
    end
  end

  // Line decoder: every sample of a bit must equal the first; whole frame is one comparison
  bit          mon_active = 0;
  int          mon_cnt, mon_d, mon_nb;
  bit          mon_pen, mon_odd, mon_glitch;
  logic [0:10] mon_line;
  initial begin
    forever begin
      @(negedge clk);
      if (rst_e) begin
        mon_active = 0;
      end else begin
        if (!mon_active && tx === 1'b0) begin
          mon_active = 1;
          mon_cnt    = 0;
          mon_d      = cfg_div_e;
          mon_pen    = cfg_pen_e;
          mon_odd    = cfg_odd_e;
          mon_nb     = mon_pen ? 11 : 10;
          mon_glitch = 0;
          mon_line   = '1;
          start_q.push_back(cyc);
        end
        if (mon_active) begin
          if (mon_cnt % mon_d == 0) mon_line[mon_cnt / mon_d] = tx;
          else if (tx !== mon_line[mon_cnt / mon_d]) mon_glitch = 1;
          mon_cnt++;
          if (mon_cnt == mon_nb * mon_d) begin
            mon_active = 0;
            frames_seen++;
            n_tests++;
            if (exp_q.size() == 0) begin
              n_fail++;
              $display("FAIL frame: got unexpected frame line=%b expected no frame", mon_line);
            end else begin
              logic [7:0]  b;
              logic [0:10] el;
              b  = exp_q.pop_front();
              el = ref_line(b, mon_pen, mon_odd);
              if (mon_glitch || mon_line !== el) begin
                n_fail++;
                $display("FAIL frame: got line=%b glitch=%0d expected line=%b (byte %h div %0d)",
                         mon_line, mon_glitch, el, b, mon_d);
              end
            end
          end
        end
      end
    end
  end

  task automatic drive_wr(input bit req, input logic [7:0] b, output bit acked);
    @(negedge clk);
    wr_req  = req;
    wr_data = b;
    #1;
    acked = req & wr_ack;
    if (acked) exp_q.push_back(b);
  endtask

  task automatic idle(input int n);
    bit a;
    for (int i = 0; i < n; i++) drive_wr(0, 8'h00, a);
  endtask

  task automatic drain(input string name);
    int  n;
    bit  a;
    n = 0;
    while ((exp_q.size() != 0 || mon_active || busy) && n < 5000) begin
      drive_wr(0, 8'h00, a);
      n++;
    end
    chk({name, "_drain_timeout"}, (n < 5000) ? 1 : 0, 1);
    chk({name, "_left_in_queue"}, exp_q.size(), 0);
  endtask

  typedef struct {
    logic [7:0]  data;
    logic [31:0] div;
    bit          pen;
    bit          odd;
    logic [0:10] line;
    int          nbits;
  } vec_t;

  vec_t vecs [7];

  initial begin
    bit          a;
    int          acks;
    int          n;
    int          deff, len, busy_end, fb;
    logic [0:10] got_line;

    rst = 1; divider = 4; parity_en = 0; parity_odd = 0; wr_req = 0; wr_data = 0;

    vecs[0] = '{8'hA5, 32'd4, 1'b0, 1'b0, 11'b01010010111, 10};
    vecs[1] = '{8'hA5, 32'd4, 1'b1, 1'b0, 11'b01010010101, 11};
    vecs[2] = '{8'hA5, 32'd4, 1'b1, 1'b1, 11'b01010010111, 11};
    vecs[3] = '{8'h01, 32'd4, 1'b1, 1'b0, 11'b01000000011, 11};
    vecs[4] = '{8'h3C, 32'd0, 1'b0, 1'b0, 11'b00011110011, 10};
    vecs[5] = '{8'h3C, 32'd1, 1'b0, 1'b0, 11'b00011110011, 10};
    vecs[6] = '{8'hFF, 32'd3, 1'b1, 1'b1, 11'b01111111111, 11};

    // reset state
    @(negedge clk); #1;
    chk("rst_tx", tx, 1);
    chk("rst_busy", busy, 0);
    chk("rst_count", count, 0);
    chk("rst_full", full, 0);
    @(negedge clk); @(negedge clk);
    rst = 0;
    idle(2);

    // directed frames from the table
    for (int v = 0; v < 7; v++) begin
      drain($sformatf("vec%0d_pre", v));
      divider = vecs[v].div; parity_en = vecs[v].pen; parity_odd = vecs[v].odd;
      deff = (vecs[v].div == 0) ? 1 : int'(vecs[v].div);
      len  = vecs[v].nbits * deff;
      drive_wr(1, vecs[v].data, a);
      drive_wr(0, 8'h00, a);
      chk($sformatf("vec%0d_prefall_tx", v), tx, 1);
      got_line = '1;
      busy_end = -1;
      for (int c = 0; c <= len + 2; c++) begin
        drive_wr(0, 8'h00, a);
        if (c < len && c % deff == 0) got_line[c / deff] = tx;
        if (busy_end < 0 && !busy) busy_end = c;
      end
      chk($sformatf("vec%0d_line", v), int'(got_line), int'(vecs[v].line));
      chk($sformatf("vec%0d_busy_cycles", v), busy_end, len);
    end
    drain("table");

    // back-to-back: three bytes in consecutive cycles, no idle gap between frames
    divider = 4; parity_en = 0; parity_odd = 0;
    start_q.delete();
    drive_wr(1, 8'h00, a);
    drive_wr(1, 8'hFF, a);
    chk("b2b_count1", count, 1);
    drive_wr(1, 8'h55, a);
    chk("b2b_count2", count, 1);
    drive_wr(0, 8'h00, a);
    chk("b2b_count3", count, 2);
    drain("b2b");
    chk("b2b_count_end", count, 0);
    chk("b2b_frames", start_q.size(), 3);
    if (start_q.size() == 3) begin
      chk("b2b_gap1", start_q[1] - start_q[0], 40);
      chk("b2b_gap2", start_q[2] - start_q[1], 40);
    end

    // full FIFO: hold the request for 12 cycles
    acks = 0;
    for (int i = 0; i < 12; i++) begin
      drive_wr(1, 8'h10 + 8'(i), a);
      if (a) acks++;
      if (i == 11) begin
        chk("full_flag", full, 1);
        chk("full_ack", wr_ack, 0);
      end
    end
    drive_wr(0, 8'h00, a);
    chk("full_acks", acks, 9);
    drain("full");

    // divider change in mid-frame only affects the next frame
    divider = 4;
    drive_wr(1, 8'h96, a);
    idle(10);
    divider = 2;
    drain("divchg1");
    drive_wr(1, 8'h69, a);
    drain("divchg2");

    // reset during data bit 3
    divider = 4; parity_en = 0;
    start_q.delete();
    drive_wr(1, 8'h5A, a);
    drive_wr(1, 8'h33, a);
    n = 0;
    while (start_q.size() == 0 && n < 50) begin
      drive_wr(0, 8'h00, a);
      n++;
    end
    chk("rstmid_started", (start_q.size() > 0) ? 1 : 0, 1);
    idle(16);
    @(negedge clk);
    rst = 1;
    @(posedge clk); #1;
    exp_q.delete();
    chk("rstmid_tx", tx, 1);
    chk("rstmid_count", count, 0);
    chk("rstmid_busy", busy, 0);
    @(negedge clk);
    rst = 0;
    fb = frames_seen;
    idle(60);
    chk("rstmid_no_residual", frames_seen, fb);
    drive_wr(1, 8'hC3, a);
    drain("rstmid_new");

    // random traffic with configuration changing every cycle
    for (int i = 0; i < 40; i++) begin
      int gap;
      gap = $urandom_range(0, 3);
      for (int g = 0; g <= gap; g++) begin
        divider    = $urandom_range(0, 5);
        parity_en  = 1'($urandom_range(0, 1));
        parity_odd = 1'($urandom_range(0, 1));
        if (g == gap) drive_wr(1, 8'($urandom), a);
        else          drive_wr(0, 8'h00, a);
      end
    end
    drain("random");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
